// File: rtl/rob_pkg.sv
// Shared types for the ROB retire stage: the ROB entry layout and the retire FSM states.
package rob_pkg;

  localparam int PREG_W = 6;
  localparam int AREG_W = 5;

  typedef struct packed {
    logic              done;
    logic              exc;
    logic              rd_valid;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic [31:0]       pc;
  } rob_entry_t;

  localparam int ENTRY_W = $bits(rob_entry_t);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } retire_state_t;

endpackage

// File: rtl/rob_retire_up_counter.sv
// Free-running enable-gated up counter; wraps naturally at 2^W.
module up_counter #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_aL_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_aL_i) begin
    if (!rst_aL_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rob_retire.sv
// In-order retire stage: pops completed ROB heads, issues registered commit/free writes,
// and on an excepting head pulses flush and drains the ROB, freeing squashed mappings.
module rob_retire
  import rob_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC   = 32'h0,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst_aL,
  input  logic              deq_valid,
  input  rob_entry_t        deq_data,
  output logic              deq_ready,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic [31:0]       epc,
  output logic              draining,
  output logic [63:0]       instret,
  output logic              watchdog_err
);

  // Handshake: an entry leaves the ROB on a cycle where deq_valid && deq_ready.
  // deq_ready is a function of state and the head entry only, never of the output registers.

  localparam int CTR_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(WDOG_LIMIT - 1);

  retire_state_t     state_q, state_d;
  logic              commit_valid_q, commit_valid_d;
  logic [AREG_W-1:0] commit_areg_q, commit_areg_d;
  logic [PREG_W-1:0] commit_preg_q, commit_preg_d;
  logic              free_valid_q, free_valid_d;
  logic [PREG_W-1:0] free_preg_q, free_preg_d;
  logic              flush_q, flush_d;
  logic [31:0]       epc_q, epc_d;
  logic              wdog_q, wdog_d;
  logic [CTR_W-1:0]  stall_q, stall_d;
  logic              retire_inc;

  always_comb begin
    state_d        = state_q;
    deq_ready      = 1'b0;
    commit_valid_d = 1'b0;
    commit_areg_d  = '0;
    commit_preg_d  = '0;
    free_valid_d   = 1'b0;
    free_preg_d    = '0;
    flush_d        = 1'b0;
    epc_d          = epc_q;
    wdog_d         = wdog_q;
    stall_d        = '0;
    retire_inc     = 1'b0;
    case (state_q)
      RUN: begin
        if (deq_valid && deq_data.done) begin
          deq_ready = 1'b1;
          if (deq_data.exc) begin
            flush_d = 1'b1;
            epc_d   = deq_data.pc;
            state_d = DRAIN;
          end else begin
            retire_inc     = 1'b1;
            commit_valid_d = deq_data.rd_valid;
            free_valid_d   = deq_data.rd_valid;
            if (deq_data.rd_valid) begin
              commit_areg_d = deq_data.areg;
              commit_preg_d = deq_data.preg;
              free_preg_d   = deq_data.old_preg;
            end
          end
        end else if (deq_valid) begin
          // Head present but incomplete: count stall cycles, saturating at the limit.
          if (stall_q == CTR_MAX) begin
            wdog_d  = 1'b1;
            stall_d = stall_q;
          end else begin
            stall_d = stall_q + CTR_W'(1);
          end
        end
      end
      DRAIN: begin
        deq_ready = 1'b1;
        if (deq_valid) begin
          // Squashed mapping: release the new preg, not old_preg.
          free_valid_d = deq_data.rd_valid;
          if (deq_data.rd_valid) free_preg_d = deq_data.preg;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q        <= RUN;
      commit_valid_q <= 1'b0;
      commit_areg_q  <= '0;
      commit_preg_q  <= '0;
      free_valid_q   <= 1'b0;
      free_preg_q    <= '0;
      flush_q        <= 1'b0;
      epc_q          <= '0;
      wdog_q         <= 1'b0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      commit_valid_q <= commit_valid_d;
      commit_areg_q  <= commit_areg_d;
      commit_preg_q  <= commit_preg_d;
      free_valid_q   <= free_valid_d;
      free_preg_q    <= free_preg_d;
      flush_q        <= flush_d;
      epc_q          <= epc_d;
      wdog_q         <= wdog_d;
      stall_q        <= stall_d;
    end
  end

  up_counter #(.W(64)) u_instret (
    .clk_i    (clk),
    .rst_aL_i (rst_aL),
    .en_i     (retire_inc),
    .count_o  (instret)
  );

  assign commit_valid = commit_valid_q;
  assign commit_areg  = commit_areg_q;
  assign commit_preg  = commit_preg_q;
  assign free_valid   = free_valid_q;
  assign free_preg    = free_preg_q;
  assign flush        = flush_q;
  assign redirect_pc  = flush_q ? TRAP_VEC : 32'h0;
  assign epc          = epc_q;
  assign draining     = (state_q == DRAIN);
  assign watchdog_err = wdog_q;

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed vector table, hand-written corner sequences, and random
// traffic compared every cycle against a behavioural model of the retire rules.
module tb_rob_retire;
  import rob_pkg::*;

  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam int          WDOG = 4;

  logic              clk = 1'b0;
  logic              rst_aL = 1'b0;
  logic              deq_valid = 1'b0;
  rob_entry_t        deq_data = '0;
  logic              deq_ready;
  logic              commit_valid;
  logic [AREG_W-1:0] commit_areg;
  logic [PREG_W-1:0] commit_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic [31:0]       epc;
  logic              draining;
  logic [63:0]       instret;
  logic              watchdog_err;

  rob_retire #(.TRAP_VEC(TRAP), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .rst_aL(rst_aL), .deq_valid(deq_valid), .deq_data(deq_data),
    .deq_ready(deq_ready), .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_preg(commit_preg), .free_valid(free_valid), .free_preg(free_preg),
    .flush(flush), .redirect_pc(redirect_pc), .epc(epc), .draining(draining),
    .instret(instret), .watchdog_err(watchdog_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic seen_ready;

  // Behavioural model: what the retire stage has promised the outside world so far.
  bit          m_drain;
  int          m_stall;
  bit          m_wdog;
  logic [63:0] m_instret;
  logic [31:0] m_epc;
  logic        m_cv, m_fv, m_flush;
  logic [AREG_W-1:0] m_areg;
  logic [PREG_W-1:0] m_cpreg, m_fpreg;

  typedef struct packed {
    logic              v;
    rob_entry_t        e;
    logic              exp_ready;
    logic              exp_cv;
    logic [AREG_W-1:0] exp_areg;
    logic [PREG_W-1:0] exp_cpreg;
    logic              exp_fv;
    logic [PREG_W-1:0] exp_fpreg;
    logic              exp_flush;
    logic              exp_drain;
    logic [63:0]       exp_instret;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic rob_entry_t mk(input logic d, input logic x, input logic rd,
                                    input int a, input int p, input int op, input logic [31:0] pc);
    rob_entry_t e;
    e.done = d; e.exc = x; e.rd_valid = rd;
    e.areg = AREG_W'(a); e.preg = PREG_W'(p); e.old_preg = PREG_W'(op); e.pc = pc;
    return e;
  endfunction

  task automatic model_reset();
    m_drain = 0; m_stall = 0; m_wdog = 0; m_instret = '0; m_epc = '0;
    m_cv = 0; m_fv = 0; m_flush = 0; m_areg = '0; m_cpreg = '0; m_fpreg = '0;
  endtask

  function automatic logic model_ready(input logic v, input rob_entry_t e);
    if (m_drain) return 1'b1;
    return v && e.done;
  endfunction

  task automatic model_update(input logic v, input rob_entry_t e);
    m_cv = 0; m_fv = 0; m_flush = 0; m_areg = '0; m_cpreg = '0; m_fpreg = '0;
    if (m_drain) begin
      m_stall = 0;
      if (v) begin
        m_fv = e.rd_valid;
        if (e.rd_valid) m_fpreg = e.preg;
      end else begin
        m_drain = 0;
      end
    end else if (v && e.done && e.exc) begin
      m_stall = 0; m_flush = 1; m_epc = e.pc; m_drain = 1;
    end else if (v && e.done) begin
      m_stall = 0; m_instret = m_instret + 64'd1;
      m_cv = e.rd_valid; m_fv = e.rd_valid;
      if (e.rd_valid) begin
        m_areg = e.areg; m_cpreg = e.preg; m_fpreg = e.old_preg;
      end
    end else if (v) begin
      m_stall = m_stall + 1;
      if (m_stall >= WDOG) m_wdog = 1;
    end else begin
      m_stall = 0;
    end
  endtask

  task automatic check_all();
    check("commit_valid", commit_valid, m_cv);
    check("commit_areg", commit_areg, m_areg);
    check("commit_preg", commit_preg, m_cpreg);
    check("free_valid", free_valid, m_fv);
    check("free_preg", free_preg, m_fpreg);
    check("flush", flush, m_flush);
    check("redirect_pc", redirect_pc, m_flush ? TRAP : 32'h0);
    check("epc", epc, m_epc);
    check("draining", draining, m_drain);
    check("instret", instret, m_instret);
    check("watchdog_err", watchdog_err, m_wdog);
  endtask

  // Called just after a negedge: drive, check ready, clock, check registered outputs.
  task automatic step(input logic v, input rob_entry_t e);
    deq_valid = v;
    deq_data  = e;
    #1;
    seen_ready = deq_ready;
    check("deq_ready", deq_ready, model_ready(v, e));
    @(posedge clk);
    model_update(v, e);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    deq_valid = 0;
    rst_aL = 0;
    @(posedge clk);
    @(negedge clk);
    rst_aL = 1;
    model_reset();
  endtask

  initial begin
    rob_entry_t e;
    model_reset();

    // Power-on reset held across clock edges.
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_all();
    check("reset_ready", deq_ready, 1'b0);
    rst_aL = 1;

    // Directed table.
    vecs[0] = '{1'b1, mk(1,0,1,5,40,12,32'h10), 1'b1, 1'b1, 5'd5, 6'd40, 1'b1, 6'd12, 1'b0, 1'b0, 64'd1};
    vecs[1] = '{1'b1, mk(1,0,0,0,7,9,32'h14),   1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 64'd2};
    vecs[2] = '{1'b0, mk(0,0,0,0,0,0,32'h0),    1'b0, 1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 64'd2};
    vecs[3] = '{1'b1, mk(0,0,1,3,4,5,32'h18),   1'b0, 1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 64'd2};
    vecs[4] = '{1'b1, mk(1,1,1,3,4,5,32'h80),   1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b1, 64'd2};
    vecs[5] = '{1'b1, mk(1,0,1,6,33,3,32'h84),  1'b1, 1'b0, 5'd0, 6'd0,  1'b1, 6'd33, 1'b0, 1'b1, 64'd2};
    vecs[6] = '{1'b1, mk(0,1,1,7,34,2,32'h88),  1'b1, 1'b0, 5'd0, 6'd0,  1'b1, 6'd34, 1'b0, 1'b1, 64'd2};
    vecs[7] = '{1'b0, mk(0,0,0,0,0,0,32'h0),    1'b1, 1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 64'd2};
    vecs[8] = '{1'b1, mk(1,0,1,31,63,1,32'h8c), 1'b1, 1'b1, 5'd31, 6'd63, 1'b1, 6'd1, 1'b0, 1'b0, 64'd3};
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].e);
      check("tbl_ready", seen_ready, vecs[i].exp_ready);
      check("tbl_commit_valid", commit_valid, vecs[i].exp_cv);
      check("tbl_commit_areg", commit_areg, vecs[i].exp_areg);
      check("tbl_commit_preg", commit_preg, vecs[i].exp_cpreg);
      check("tbl_free_valid", free_valid, vecs[i].exp_fv);
      check("tbl_free_preg", free_preg, vecs[i].exp_fpreg);
      check("tbl_flush", flush, vecs[i].exp_flush);
      check("tbl_draining", draining, vecs[i].exp_drain);
      check("tbl_instret", instret, vecs[i].exp_instret);
    end
    check("tbl_epc", epc, 32'h80);

    // Asynchronous reset in the middle of a drain, between clock edges.
    step(1'b1, mk(1,1,0,0,0,0,32'h44));
    check("pre_rst_flush", flush, 1'b1);
    deq_valid = 0;
    rst_aL = 0;
    #1;
    check("arst_flush", flush, 1'b0);
    check("arst_redirect", redirect_pc, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_draining", draining, 1'b0);
    check("arst_instret", instret, 64'd0);
    check("arst_commit", commit_valid, 1'b0);
    #1;
    rst_aL = 1;
    model_reset();
    step(1'b0, '0);
    step(1'b1, mk(1,0,1,2,22,11,32'h48));
    check("post_rst_commit", commit_valid, 1'b1);

    // Watchdog: head stalled WDOG cycles.
    e = mk(0,0,1,4,44,14,32'h50);
    for (int i = 0; i < WDOG; i++) begin
      step(1'b1, e);
      check("stall_ready", seen_ready, 1'b0);
      check("wdog_level", watchdog_err, (i == WDOG - 1) ? 1'b1 : 1'b0);
    end
    e.done = 1;
    step(1'b1, e);
    check("wdog_sticky_pop", watchdog_err, 1'b1);
    step(1'b0, '0);
    check("wdog_sticky_idle", watchdog_err, 1'b1);

    // Exception with three younger entries behind it.
    do_reset();
    step(1'b1, mk(1,1,1,9,19,8,32'h80));
    check("exc_flush", flush, 1'b1);
    check("exc_redirect", redirect_pc, TRAP);
    check("exc_epc", epc, 32'h80);
    check("exc_no_commit", commit_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1, 10+i, 20+i, 30+i, 32'h84 + 32'(4*i)));
      check("drain_ready", seen_ready, 1'b1);
      check("drain_free_valid", free_valid, 1'b1);
      check("drain_free_preg", free_preg, 6'(20+i));
      check("drain_no_commit", commit_valid, 1'b0);
      check("drain_no_flush", flush, 1'b0);
      check("drain_epc", epc, 32'h80);
    end
    step(1'b0, '0);
    check("drain_exit", draining, 1'b0);
    step(1'b1, mk(1,0,1,1,2,3,32'h90));
    check("run_commit", commit_valid, 1'b1);

    // Back-to-back retires.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mk(1,0,1,i+1,i+8,i+16,32'h200 + 32'(4*i)));
      check("b2b_commit_valid", commit_valid, 1'b1);
      check("b2b_instret", instret, 64'(i+1));
    end
    step(1'b0, '0);
    check("b2b_final_instret", instret, 64'd8);
    check("b2b_idle", commit_valid, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      e = mk(1'($urandom_range(0,3) != 0), 1'($urandom_range(0,7) == 0), 1'($urandom_range(0,1)),
             int'($urandom_range(0,31)), int'($urandom_range(0,63)), int'($urandom_range(0,63)),
             32'($urandom));
      step(1'($urandom_range(0,3) != 0), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
